// File: rtl/jt12_kon_wr_if.sv
// ============================================================================
// Module   : jt12_kon_wr_if
// Brief    : CPU write bus and key-on update outputs of the key-on writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface jt12_kon_wr_if;
    logic       cpu_wr;
    logic [1:0] cpu_a;
    logic [7:0] cpu_din;
    logic       up_keyon;
    logic [2:0] keyon_ch;
    logic [3:0] keyon_op;
    logic       busy;

    modport master (
        output cpu_wr, cpu_a, cpu_din,
        input  up_keyon, keyon_ch, keyon_op, busy
    );

    modport slave (
        input  cpu_wr, cpu_a, cpu_din,
        output up_keyon, keyon_ch, keyon_op, busy
    );
endinterface

`default_nettype wire

// File: rtl/jt12_kon_wr.sv
// ============================================================================
// Module   : jt12_kon_wr
// Brief    : Turns register 0x28 key-on writes into one full operator round of
//            up_keyon, with a one-entry last-write-wins command queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jt12_kon_wr #(
    parameter int SLOTS = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    jt12_kon_wr_if.slave  bus
);

    localparam int             CW         = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CW-1:0]  C_CNT_LOAD = CW'(SLOTS - 1);
    localparam logic [7:0]     C_KON_ADDR = 8'h28;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q,  addr_d;
    logic          part2_q, part2_d;
    logic          up_q,    up_d;
    logic [2:0]    ch_q,    ch_d;
    logic [3:0]    op_q,    op_d;
    logic          qv_q,    qv_d;
    logic [2:0]    qch_q,   qch_d;
    logic [3:0]    qop_q,   qop_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          w_cmd_ok;
    logic [2:0]    w_cmd_ch;
    logic [3:0]    w_cmd_op;

    // Channels 3 and 7 do not exist; both have the low two bits set.
    assign w_cmd_ch = bus.cpu_din[2:0];
    assign w_cmd_op = bus.cpu_din[7:4];
    assign w_cmd_ok = bus.cpu_wr && (bus.cpu_a == 2'd1) && (addr_q == C_KON_ADDR)
                      && !part2_q && (w_cmd_ch[1:0] != 2'b11);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        part2_d = part2_q;
        up_d    = up_q;
        ch_d    = ch_q;
        op_d    = op_q;
        qv_d    = qv_q;
        qch_d   = qch_q;
        qop_d   = qop_q;
        cnt_d   = cnt_q;

        if (bus.cpu_wr && (bus.cpu_a == 2'd0)) begin
            addr_d  = bus.cpu_din;
            part2_d = 1'b0;
        end else if (bus.cpu_wr && (bus.cpu_a == 2'd2)) begin
            addr_d  = bus.cpu_din;
            part2_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_cmd_ok) begin
                    ch_d    = w_cmd_ch;
                    op_d    = w_cmd_op;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (clk_en) begin
                    state_d = S_APPLY;
                    up_d    = 1'b1;
                    cnt_d   = C_CNT_LOAD;
                end
                if (w_cmd_ok) begin
                    qv_d  = 1'b1;
                    qch_d = w_cmd_ch;
                    qop_d = w_cmd_op;
                end
            end
            S_APPLY: begin
                if (clk_en && (cnt_q == '0)) begin
                    up_d = 1'b0;
                    // The queue is popped first; a command on this same edge lands behind it.
                    if (qv_q) begin
                        ch_d    = qch_q;
                        op_d    = qop_q;
                        state_d = S_ARM;
                        qv_d    = w_cmd_ok;
                        if (w_cmd_ok) begin
                            qch_d = w_cmd_ch;
                            qop_d = w_cmd_op;
                        end
                    end else if (w_cmd_ok) begin
                        ch_d    = w_cmd_ch;
                        op_d    = w_cmd_op;
                        state_d = S_ARM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (clk_en) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                    if (w_cmd_ok) begin
                        qv_d  = 1'b1;
                        qch_d = w_cmd_ch;
                        qop_d = w_cmd_op;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                up_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            part2_q <= 1'b0;
            up_q    <= 1'b0;
            ch_q    <= 3'd0;
            op_q    <= 4'd0;
            qv_q    <= 1'b0;
            qch_q   <= 3'd0;
            qop_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            part2_q <= part2_d;
            up_q    <= up_d;
            ch_q    <= ch_d;
            op_q    <= op_d;
            qv_q    <= qv_d;
            qch_q   <= qch_d;
            qop_q   <= qop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.up_keyon = up_q;
    assign bus.keyon_ch = ch_q;
    assign bus.keyon_op = op_q;
    assign bus.busy     = qv_q;

endmodule

`default_nettype wire

// File: tb/tb_jt12_kon_wr.sv
// ============================================================================
// Module   : tb_jt12_kon_wr
// Brief    : Self-checking bench for jt12_kon_wr against a round/queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jt12_kon_wr;

    localparam int SLOTS = 24;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b0;

    jt12_kon_wr_if bus ();

    jt12_kon_wr #(.SLOTS(SLOTS)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // clk_en pattern: en_div=N gives one pulse every N clks, en_div=0 is random
    int en_div = 1;
    int en_ph  = 0;
    always @(negedge clk) begin
        if (en_div == 0) begin
            clk_en = ($urandom_range(0, 2) != 0);
        end else begin
            en_ph  = (en_ph + 1) % en_div;
            clk_en = (en_ph == 0);
        end
    end

    // Model: a round lasts SLOTS+1 clk_en pulses once loaded; up_keyon is high
    // after the first pulse until the last one. Pending commands sit in a queue.
    logic [7:0] m_addr;
    bit         m_p2;
    bit         m_cur;
    logic [2:0] m_ch;
    logic [3:0] m_op;
    int         m_pulses;
    logic [6:0] m_pend[$];
    bit         m_live = 1'b0;

    always @(posedge clk) begin : model
        bit v;
        if (rst) begin
            m_addr   = 8'h00;
            m_p2     = 1'b0;
            m_cur    = 1'b0;
            m_ch     = 3'd0;
            m_op     = 4'd0;
            m_pulses = 0;
            m_pend.delete();
            m_live   = 1'b1;
        end else begin
            v = bus.cpu_wr && (bus.cpu_a == 2'd1) && (m_addr == 8'h28) && !m_p2
                && !(bus.cpu_din[2:0] inside {3'd3, 3'd7});
            if (bus.cpu_wr && (bus.cpu_a == 2'd0)) begin m_addr = bus.cpu_din; m_p2 = 1'b0; end
            if (bus.cpu_wr && (bus.cpu_a == 2'd2)) begin m_addr = bus.cpu_din; m_p2 = 1'b1; end
            if (m_cur && clk_en) begin
                if (m_pulses == SLOTS) begin
                    m_pulses = 0;
                    if (m_pend.size() > 0) {m_op, m_ch} = m_pend.pop_front();
                    else m_cur = 1'b0;
                end else begin
                    m_pulses++;
                end
            end
            if (v) begin
                if (!m_cur) begin
                    m_cur    = 1'b1;
                    m_ch     = bus.cpu_din[2:0];
                    m_op     = bus.cpu_din[7:4];
                    m_pulses = 0;
                end else begin
                    m_pend.delete();
                    m_pend.push_back({bus.cpu_din[7:4], bus.cpu_din[2:0]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("up_keyon", 32'(bus.up_keyon), 32'(m_cur && (m_pulses >= 1)));
            check("keyon_ch", 32'(bus.keyon_ch), 32'(m_ch));
            check("keyon_op", 32'(bus.keyon_op), 32'(m_op));
            check("busy",     32'(bus.busy),     32'(m_pend.size() != 0));
        end
    end

    // Pulse counters: clk_en edges, and those seen with up_keyon already high
    bit up_prev = 1'b0;
    int en_cnt  = 0;
    int hi_cnt  = 0;
    always @(negedge clk) up_prev = bus.up_keyon;
    always @(posedge clk) begin
        #1;
        if (clk_en) begin
            en_cnt++;
            if (up_prev) hi_cnt++;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_wr  = 1'b1;
        bus.cpu_a   = a;
        bus.cpu_din = d;
        @(negedge clk);
        bus.cpu_wr  = 1'b0;
    endtask

    task automatic wait_up(input logic lvl, input int budget, input string name);
        int n = 0;
        while (bus.up_keyon !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.up_keyon !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: up_keyon stayed %0b, wanted %0b", name, bus.up_keyon, lvl);
        end
    endtask

    initial begin
        int hi0, lo0, n;
        logic [1:0] a;
        bus.cpu_wr  = 1'b0;
        bus.cpu_a   = 2'd0;
        bus.cpu_din = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_up",   32'(bus.up_keyon), 32'd0);
        check("rst_ch",   32'(bus.keyon_ch), 32'd0);
        check("rst_op",   32'(bus.keyon_op), 32'd0);
        check("rst_busy", 32'(bus.busy),     32'd0);
        rst = 1'b0;

        // Basic key-on, clk_en every clk
        wr(2'd0, 8'h28);
        hi0 = hi_cnt;
        wr(2'd1, 8'hF1);
        check("basic_ch",    32'(bus.keyon_ch), 32'd1);
        check("basic_op",    32'(bus.keyon_op), 32'hF);
        check("basic_up_lo", 32'(bus.up_keyon), 32'd0);
        @(negedge clk);
        check("basic_up_hi", 32'(bus.up_keyon), 32'd1);
        wait_up(1'b0, 100, "basic_fall");
        check("basic_pulses", 32'(hi_cnt - hi0), 32'd24);

        // Part-II key-on and nonexistent channel are ignored
        wr(2'd2, 8'h28);
        wr(2'd3, 8'hF1);
        repeat (4) @(negedge clk);
        check("p2_up",   32'(bus.up_keyon), 32'd0);
        check("p2_busy", 32'(bus.busy),     32'd0);
        wr(2'd0, 8'h28);
        wr(2'd1, 8'h13);
        repeat (4) @(negedge clk);
        check("ch3_up", 32'(bus.up_keyon), 32'd0);
        check("ch3_ch", 32'(bus.keyon_ch), 32'd1);

        // Two writes during a round: last one wins
        wr(2'd1, 8'h21);
        wait_up(1'b1, 10, "q_rise");
        wr(2'd1, 8'h15);
        wr(2'd1, 8'h26);
        check("q_busy", 32'(bus.busy),     32'd1);
        check("q_ch0",  32'(bus.keyon_ch), 32'd1);
        wait_up(1'b0, 100, "q_fall");
        wait_up(1'b1, 10, "q_rise2");
        check("q_ch",    32'(bus.keyon_ch), 32'd6);
        check("q_op",    32'(bus.keyon_op), 32'd2);
        check("q_busy2", 32'(bus.busy),     32'd0);
        wait_up(1'b0, 100, "q_fall2");

        // clk_en every third clk
        en_div = 3;
        hi0 = hi_cnt;
        wr(2'd1, 8'h84);
        wait_up(1'b1, 20, "div3_rise");
        check("div3_ch", 32'(bus.keyon_ch), 32'd4);
        check("div3_op", 32'(bus.keyon_op), 32'd8);
        n = 0;
        while (bus.up_keyon === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("div3_clks",   32'(n),             32'd72);
        check("div3_pulses", 32'(hi_cnt - hi0),  32'd24);

        // Command landing on the exit edge with an empty queue
        en_div = 1;
        repeat (3) @(negedge clk);
        wr(2'd1, 8'h21);
        wait_up(1'b1, 10, "exit_rise");
        repeat (22) @(negedge clk);
        wr(2'd1, 8'h42);
        check("exit_up",   32'(bus.up_keyon), 32'd0);
        check("exit_ch",   32'(bus.keyon_ch), 32'd2);
        check("exit_op",   32'(bus.keyon_op), 32'd4);
        check("exit_busy", 32'(bus.busy),     32'd0);
        lo0 = en_cnt - hi_cnt;
        wait_up(1'b1, 10, "exit_rise2");
        check("exit_gap", 32'(en_cnt - hi_cnt - lo0), 32'd1);
        wait_up(1'b0, 100, "exit_fall");

        // Reset mid-round with a full queue and a simultaneous valid write
        wr(2'd1, 8'h21);
        wait_up(1'b1, 10, "rst_rise");
        wr(2'd1, 8'h42);
        check("rst_qbusy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst         = 1'b1;
        bus.cpu_wr  = 1'b1;
        bus.cpu_a   = 2'd1;
        bus.cpu_din = 8'h21;
        @(negedge clk);
        rst         = 1'b0;
        bus.cpu_wr  = 1'b0;
        check("abort_up",   32'(bus.up_keyon), 32'd0);
        check("abort_busy", 32'(bus.busy),     32'd0);
        check("abort_ch",   32'(bus.keyon_ch), 32'd0);
        hi0 = hi_cnt;
        repeat (60) @(negedge clk);
        check("abort_quiet", 32'(hi_cnt - hi0), 32'd0);

        // Random traffic
        en_div = 0;
        wr(2'd0, 8'h28);
        repeat (4000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            bus.cpu_wr = ($urandom_range(0, 99) < 40);
            n = $urandom_range(0, 9);
            a = (n <= 5) ? 2'd1 : (n == 7) ? 2'd2 : (n == 8) ? 2'd3 : 2'd0;
            bus.cpu_a = a;
            if ((a == 2'd0 || a == 2'd2) && $urandom_range(0, 9) != 0)
                bus.cpu_din = 8'h28;
            else
                bus.cpu_din = 8'($urandom);
        end
        @(negedge clk);
        rst        = 1'b0;
        bus.cpu_wr = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jt12_kon_wr.md
JT12_KON_WR -- requirements
Module: jt12_kon_wr

Interface
REQ-001 SHALL have parameter SLOTS, default 24, number of clk_en-qualified slot cycles per full operator round.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port clk_en  input  1  slot-advance enable; one pulse = one operator slot.
REQ-005 SHALL have port cpu_wr  input  1  one-clk bus write strobe, sampled on any clk edge regardless of clk_en.
REQ-006 SHALL have port cpu_a  input  2  bus address: 0 = part-I address, 1 = part-I data, 2 = part-II address, 3 = part-II data.
REQ-007 SHALL have port cpu_din  input  8  bus write data.
REQ-008 SHALL have port up_keyon  output  1  key-on update active; held for exactly SLOTS clk_en pulses per command.
REQ-009 SHALL have port keyon_ch  output  3  target channel, stable while up_keyon=1.
REQ-010 SHALL have port keyon_op  output  4  operator key bits {S4,S3,S2,S1}, stable while up_keyon=1.
REQ-011 SHALL have port busy  output  1  1 while the one-entry command queue holds a command.

Function
REQ-012 SHALL latch an 8-bit address register on cpu_wr with cpu_a=0, and clear a part-II flag.
REQ-013 SHALL latch cpu_din into the address register on cpu_wr with cpu_a=2, and set the part-II flag.
REQ-014 SHALL accept a key-on command only on cpu_wr with cpu_a=1, address register=0x28, and part-II flag=0; all other data writes SHALL be ignored.
REQ-015 SHALL decode the command as ch=cpu_din[2:0], op=cpu_din[7:4].
REQ-016 SHALL discard commands with ch=3 or ch=7 with no state change.
REQ-017 SHALL implement states IDLE, ARM, APPLY.
REQ-018 IDLE: valid command -> latch ch/op into output registers, go ARM on the next clk; up_keyon=0.
REQ-019 ARM: on the first clk_en pulse, go APPLY, set up_keyon=1, load the slot counter with SLOTS-1.
REQ-020 APPLY: decrement the slot counter on each clk_en; on the clk_en pulse with counter=0, clear up_keyon.
REQ-021 APPLY exit: go ARM with queued command loaded into ch/op if queue full, and clear queue; otherwise go IDLE.
REQ-022 up_keyon SHALL therefore be high for exactly SLOTS clk_en pulses, covering every operator of keyon_ch once.
REQ-023 keyon_ch/keyon_op SHALL NOT change while up_keyon=1.
REQ-024 A valid command arriving in ARM or APPLY SHALL go into the one-entry queue; busy=1 from the next clk.
REQ-025 A valid command arriving while the queue is full SHALL overwrite the queued entry (last write wins); busy stays 1.
REQ-026 A command arriving on the same clk as the APPLY-exit pulse SHALL be treated as arriving after the queue pop: it becomes the queued entry behind the popped one, or is loaded directly into ARM if the queue was empty.
REQ-027 Slot counter width SHALL be clog2(SLOTS); no wrap past 0.
REQ-028 clk_en=0 SHALL freeze ARM/APPLY progress; CPU writes are still captured.

Reset
REQ-029 On rst=1 at a clk edge: state=IDLE, up_keyon=0, keyon_ch=0, keyon_op=0, busy=0, address register=0, part-II flag=0, counter=0.
REQ-030 rst SHALL override a simultaneous cpu_wr and an APPLY in progress; an aborted command SHALL NOT resume.

Verification
REQ-031 Write a0=0x28, a1=0xF1, clk_en every clk -> keyon_ch=1, keyon_op=0xF; up_keyon high for 24 clk_en pulses starting 2 clks after the write.
REQ-032 Write a2=0x28, a3=0xF1 -> no up_keyon, busy=0; write a1=0x13 with addr 0x28 -> ignored (ch=3).
REQ-033 Two writes 0x15 then 0x26 during APPLY -> busy=1; current round completes; next round applies ch=6, op=0x2; 0x15's queued entry is lost.
REQ-034 clk_en every 3rd clk, command 0x84 -> up_keyon spans exactly 24 clk_en pulses (72 clks); ch/op are stable throughout.
REQ-035 rst asserted mid-APPLY with queue full -> next clk: up_keyon=0, busy=0, state IDLE; no further up_keyon without new writes.
REQ-036 Command written on the same clk as the APPLY-exit pulse with queue empty -> immediate ARM with the new ch/op; up_keyon low for exactly one clk_en pulse between rounds.
